// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-transfer logic: requester and
// arbiter state encodings, line geometry, and the round-robin successor.
package cache_pkg;

    // Requester identities; the numeric order is the round-robin order.
    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_DF = 2'd1,
        REQ_WB = 2'd2
    } req_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // 32-byte cache line: byte offset occupies address bits [4:0].
    localparam int          LINE_OFFSET_B  = 5;
    localparam logic [31:0] LINE_BASE_MASK = ~((32'd1 << LINE_OFFSET_B) - 32'd1);

    // Requester that follows r in the rotation IF -> DF -> WB -> IF.
    function automatic req_e next_req(input req_e r);
        case (r)
            REQ_IF:  return REQ_DF;
            REQ_DF:  return REQ_WB;
            default: return REQ_IF;
        endcase
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the three cache requester channels plus the word-serial memory
// port. "master" is the arbiter's view; "slave" is the view of everything
// around it (cache line buffers on one side, the memory bridge on the other).
interface cache_mem_arbiter_if #(
    parameter int WIDX_W = 3
);
    // I-cache line fill
    logic              IF_Req;
    logic [31:0]       IF_Addr;
    logic              IF_Valid;
    logic [31:0]       IF_Data;
    logic [WIDX_W-1:0] IF_WordIdx;
    logic              IF_FirstWord;
    logic              IF_Completed;

    // D-cache line fill
    logic              DF_Req;
    logic [31:0]       DF_Addr;
    logic              DF_Valid;
    logic [31:0]       DF_Data;
    logic [WIDX_W-1:0] DF_WordIdx;
    logic              DF_FirstWord;
    logic              DF_Completed;

    // D-cache dirty-line write-back
    logic              WB_Req;
    logic [31:0]       WB_Addr;
    logic [WIDX_W-1:0] WB_WordIdx;
    logic [31:0]       WB_WData;
    logic              WB_Completed;

    // External memory beat port
    logic              Mem_Req;
    logic              Mem_Wr;
    logic [31:0]       Mem_Addr;
    logic [31:0]       Mem_WData;
    logic              Mem_Ack;
    logic [31:0]       Mem_RData;

    modport master (
        input  IF_Req, IF_Addr, DF_Req, DF_Addr, WB_Req, WB_Addr, WB_WData,
               Mem_Ack, Mem_RData,
        output IF_Valid, IF_Data, IF_WordIdx, IF_FirstWord, IF_Completed,
               DF_Valid, DF_Data, DF_WordIdx, DF_FirstWord, DF_Completed,
               WB_WordIdx, WB_Completed,
               Mem_Req, Mem_Wr, Mem_Addr, Mem_WData
    );

    modport slave (
        output IF_Req, IF_Addr, DF_Req, DF_Addr, WB_Req, WB_Addr, WB_WData,
               Mem_Ack, Mem_RData,
        input  IF_Valid, IF_Data, IF_WordIdx, IF_FirstWord, IF_Completed,
               DF_Valid, DF_Data, DF_WordIdx, DF_FirstWord, DF_Completed,
               WB_WordIdx, WB_Completed,
               Mem_Req, Mem_Wr, Mem_Addr, Mem_WData
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way rotating-priority arbiter: the requester named by ptr has the
// highest priority, followed by the others in IF -> DF -> WB -> IF order.
module rr_arbiter3
    import cache_pkg::*;
(
    input  logic [2:0] req,
    input  req_e       ptr,
    output logic [2:0] grant
);

    // Pick the first active request walking the rotation from ptr.
    always_comb begin
        // NOTE: grant gets a default before any branch so every path assigns
        // it; a missing default here would infer a latch.
        grant = 3'b000;
        case (ptr)
            REQ_DF: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            REQ_WB: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-serial memory port between I-cache fill, D-cache fill and
// D-cache write-back. Each grant covers one whole line burst; fills start at
// the critical word and wrap, write-backs start at word 0.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 1 << (LINE_OFFSET_B - 2),
    parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                Clk,
    input  logic                Rst,
    cache_mem_arbiter_if.master bus,
    output logic                Busy
);

    // Clears the byte offset of a whole line for the configured line size.
    localparam logic [31:0] BASE_MASK = ~((32'(LINE_WORDS) << 2) - 32'd1);

    state_e            state_q, state_d;
    req_e              gnt_q;
    req_e              ptr_q;
    logic [31:0]       base_q;
    logic [WIDX_W-1:0] start_q;
    logic [WIDX_W-1:0] cnt_q;
    logic              wr_q;

    logic [2:0]        req_vec;
    logic [2:0]        grant;
    req_e              gnt_sel;
    logic [31:0]       addr_sel;
    logic [WIDX_W-1:0] idx;
    logic              beat_ack;
    logic              last_beat;

    assign req_vec   = {bus.WB_Req, bus.DF_Req, bus.IF_Req};
    // Word index wraps naturally through the WIDX_W-bit sum.
    assign idx       = start_q + cnt_q;
    assign beat_ack  = (state_q == XFER) && bus.Mem_Ack;
    assign last_beat = (cnt_q == WIDX_W'(LINE_WORDS - 1));

    rr_arbiter3 u_rr (
        .req   (req_vec),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Encode the one-hot grant and select the winner's address.
    always_comb begin
        gnt_sel  = REQ_IF;
        addr_sel = bus.IF_Addr;
        if (grant[1]) begin
            gnt_sel  = REQ_DF;
            addr_sel = bus.DF_Addr;
        end else if (grant[2]) begin
            gnt_sel  = REQ_WB;
            addr_sel = bus.WB_Addr;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Burst context: latched at grant, beat counter, round-robin pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            gnt_q   <= REQ_IF;
            ptr_q   <= REQ_IF;
            base_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && |req_vec) begin
                gnt_q   <= gnt_sel;
                base_q  <= addr_sel & BASE_MASK;
                start_q <= (gnt_sel == REQ_WB) ? '0 : addr_sel[WIDX_W+1:2];
                cnt_q   <= '0;
                wr_q    <= (gnt_sel == REQ_WB);
            end
            if (beat_ack) cnt_q <= cnt_q + WIDX_W'(1);
            if (state_q == DONE) ptr_q <= next_req(gnt_q);
        end
    end

    // Next state plus all outputs; idle values first, then per-state drive.
    always_comb begin
        state_d          = state_q;
        Busy             = (state_q != IDLE);
        bus.Mem_Req      = 1'b0;
        bus.Mem_Wr       = 1'b0;
        bus.Mem_Addr     = '0;
        bus.Mem_WData    = '0;
        bus.IF_Valid     = 1'b0;
        bus.IF_Data      = '0;
        bus.IF_WordIdx   = '0;
        bus.IF_FirstWord = 1'b0;
        bus.IF_Completed = 1'b0;
        bus.DF_Valid     = 1'b0;
        bus.DF_Data      = '0;
        bus.DF_WordIdx   = '0;
        bus.DF_FirstWord = 1'b0;
        bus.DF_Completed = 1'b0;
        bus.WB_WordIdx   = '0;
        bus.WB_Completed = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_vec) state_d = XFER;
            end
            XFER: begin
                bus.Mem_Req  = 1'b1;
                bus.Mem_Wr   = wr_q;
                bus.Mem_Addr = base_q + (32'(idx) << 2);
                if (wr_q) begin
                    // Write buffer presents data for idx combinationally.
                    bus.WB_WordIdx = idx;
                    bus.Mem_WData  = bus.WB_WData;
                end else if (bus.Mem_Ack) begin
                    if (gnt_q == REQ_IF) begin
                        bus.IF_Valid     = 1'b1;
                        bus.IF_Data      = bus.Mem_RData;
                        bus.IF_WordIdx   = idx;
                        bus.IF_FirstWord = (cnt_q == '0);
                    end else begin
                        bus.DF_Valid     = 1'b1;
                        bus.DF_Data      = bus.Mem_RData;
                        bus.DF_WordIdx   = idx;
                        bus.DF_FirstWord = (cnt_q == '0);
                    end
                end
                if (beat_ack && last_beat) state_d = DONE;
            end
            DONE: begin
                case (gnt_q)
                    REQ_IF:  bus.IF_Completed = 1'b1;
                    REQ_DF:  bus.DF_Completed = 1'b1;
                    default: bus.WB_Completed = 1'b1;
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: expected memory beats and
// completions are queued as stimulus is issued and consumed as the DUT acts.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int LW = 8;
    localparam int WW = 3;

    logic Clk = 1'b0;
    logic Rst;
    logic Busy;

    cache_mem_arbiter_if #(.WIDX_W(WW)) bus ();

    cache_mem_arbiter #(.LINE_WORDS(LW), .WIDX_W(WW)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .bus  (bus),
        .Busy (Busy)
    );

    always #5 Clk = ~Clk;

    // Memory and write-buffer models.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] wdata_of(input logic [WW-1:0] i);
        return 32'hB00D_0000 | 32'(i);
    endfunction

    assign bus.Mem_RData = rdata_of(bus.Mem_Addr);
    assign bus.WB_WData  = wdata_of(bus.WB_WordIdx);

    typedef struct {
        req_e          who;
        logic [31:0]   addr;
        logic [WW-1:0] idx;
        logic          first;
        logic          last;
    } beat_t;

    beat_t sbq[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   beats_seen = 0;
    logic done_pending = 1'b0;
    req_e done_who = REQ_IF;
    int   if_left, df_left, wb_left;
    int   comp_if, comp_df, comp_wb;
    int   ack_mode = 0;
    int   ack_phase = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_burst(input req_e who, input logic [31:0] addr);
        beat_t       b;
        logic [31:0] base;
        int          start;
        base  = addr & 32'hFFFF_FFE0;
        start = (who == REQ_WB) ? 0 : int'(addr[4:2]);
        for (int k = 0; k < LW; k++) begin
            int i;
            i       = (start + k) % LW;
            b.who   = who;
            b.idx   = WW'(i);
            b.addr  = base + 32'(i * 4);
            b.first = (k == 0);
            b.last  = (k == LW - 1);
            sbq.push_back(b);
        end
    endtask

    // Sampled on the falling edge: compare everything against the queue head.
    task automatic monitor();
        beat_t e;
        logic  ev_if, ev_df;
        e     = '{who: REQ_IF, addr: 32'd0, idx: '0, first: 1'b0, last: 1'b0};
        ev_if = 1'b0;
        ev_df = 1'b0;

        check("if_completed", 32'(bus.IF_Completed), 32'(done_pending && done_who == REQ_IF));
        check("df_completed", 32'(bus.DF_Completed), 32'(done_pending && done_who == REQ_DF));
        check("wb_completed", 32'(bus.WB_Completed), 32'(done_pending && done_who == REQ_WB));
        if (done_pending) check("done_mem_req", 32'(bus.Mem_Req), 32'd0);
        done_pending = 1'b0;

        if (bus.IF_Completed) begin
            comp_if++;
            if (if_left > 0) begin if_left--; if (if_left == 0) bus.IF_Req = 1'b0; end
        end
        if (bus.DF_Completed) begin
            comp_df++;
            if (df_left > 0) begin df_left--; if (df_left == 0) bus.DF_Req = 1'b0; end
        end
        if (bus.WB_Completed) begin
            comp_wb++;
            if (wb_left > 0) begin wb_left--; if (wb_left == 0) bus.WB_Req = 1'b0; end
        end

        if (bus.Mem_Req) begin
            if (sbq.size() == 0) begin
                check("unexpected_mem_req", 32'(bus.Mem_Req), 32'd0);
            end else begin
                e = sbq[0];
                check("mem_addr", bus.Mem_Addr, e.addr);
                check("mem_wr", 32'(bus.Mem_Wr), 32'(e.who == REQ_WB));
                if (e.who == REQ_WB) begin
                    check("wb_word_idx", 32'(bus.WB_WordIdx), 32'(e.idx));
                    check("mem_wdata", bus.Mem_WData, wdata_of(e.idx));
                end
                if (bus.Mem_Ack) begin
                    ev_if = (e.who == REQ_IF);
                    ev_df = (e.who == REQ_DF);
                    void'(sbq.pop_front());
                    beats_seen++;
                    if (e.last) begin
                        done_pending = 1'b1;
                        done_who     = e.who;
                    end
                end
            end
        end

        check("if_valid", 32'(bus.IF_Valid), 32'(ev_if));
        check("if_first", 32'(bus.IF_FirstWord), 32'(ev_if && e.first));
        check("if_word_idx", 32'(bus.IF_WordIdx), ev_if ? 32'(e.idx) : 32'd0);
        check("if_data", bus.IF_Data, ev_if ? rdata_of(e.addr) : 32'd0);
        check("df_valid", 32'(bus.DF_Valid), 32'(ev_df));
        check("df_first", 32'(bus.DF_FirstWord), 32'(ev_df && e.first));
        check("df_word_idx", 32'(bus.DF_WordIdx), ev_df ? 32'(e.idx) : 32'd0);
        check("df_data", bus.DF_Data, ev_df ? rdata_of(e.addr) : 32'd0);
    endtask

    // One clock: drive the memory ack just after the rising edge, check on the falling edge.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (bus.Mem_Req) begin
            ack_phase++;
            bus.Mem_Ack = (ack_mode == 0) || (ack_phase % 3 == 0);
        end else begin
            ack_phase   = 0;
            bus.Mem_Ack = 1'b0;
        end
        @(negedge Clk);
        monitor();
    endtask

    task automatic clear_counts();
        comp_if = 0; comp_df = 0; comp_wb = 0;
        if_left = 0; df_left = 0; wb_left = 0;
    endtask

    task automatic do_reset();
        Rst        = 1'b1;
        bus.IF_Req = 1'b0;
        bus.DF_Req = 1'b0;
        bus.WB_Req = 1'b0;
        sbq.delete();
        done_pending = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        clear_counts();
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sbq.size() == 0 && !done_pending) break;
            tick();
        end
        check({tag, "_drained"}, 32'(sbq.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_beats(input string tag, input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (beats_seen >= target) break;
            tick();
        end
        check({tag, "_beats_reached"}, 32'(beats_seen >= target), 32'd1);
    endtask

    initial begin
        int start;
        Rst         = 1'b1;
        bus.IF_Req  = 1'b0; bus.IF_Addr = '0;
        bus.DF_Req  = 1'b0; bus.DF_Addr = '0;
        bus.WB_Req  = 1'b0; bus.WB_Addr = '0;
        bus.Mem_Ack = 1'b0;
        clear_counts();

        // Reset state
        do_reset();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_mem_req", 32'(bus.Mem_Req), 32'd0);
        check("rst_mem_wr", 32'(bus.Mem_Wr), 32'd0);
        check("rst_mem_addr", bus.Mem_Addr, 32'd0);
        check("rst_wb_word_idx", 32'(bus.WB_WordIdx), 32'd0);

        // Critical-word-first IF fill, ack every cycle
        ack_mode = 0;
        bus.IF_Addr = 32'h0000_0014; if_left = 1; bus.IF_Req = 1'b1;
        push_burst(REQ_IF, 32'h0000_0014);
        drain("t1", 40);
        check("t1_if_completions", 32'(comp_if), 32'd1);

        // Write-back with an ack every third cycle
        do_reset();
        ack_mode = 1;
        bus.WB_Addr = 32'h0000_1234; wb_left = 1; bus.WB_Req = 1'b1;
        push_burst(REQ_WB, 32'h0000_1234);
        drain("t2", 100);
        check("t2_wb_completions", 32'(comp_wb), 32'd1);

        // All three requesters at once from reset: IF, DF, WB order
        do_reset();
        ack_mode = 0;
        bus.IF_Addr = 32'h0000_0400; bus.DF_Addr = 32'h0000_081C; bus.WB_Addr = 32'h0000_0C44;
        if_left = 1; df_left = 1; wb_left = 1;
        bus.IF_Req = 1'b1; bus.DF_Req = 1'b1; bus.WB_Req = 1'b1;
        push_burst(REQ_IF, 32'h0000_0400);
        push_burst(REQ_DF, 32'h0000_081C);
        push_burst(REQ_WB, 32'h0000_0C44);
        drain("t3", 120);
        check("t3_if_completions", 32'(comp_if), 32'd1);
        check("t3_df_completions", 32'(comp_df), 32'd1);
        check("t3_wb_completions", 32'(comp_wb), 32'd1);

        // DF held high across two bursts; IF arrives mid-burst and goes between them
        do_reset();
        bus.DF_Addr = 32'h0000_3008; df_left = 2; bus.DF_Req = 1'b1;
        push_burst(REQ_DF, 32'h0000_3008);
        start = beats_seen;
        wait_beats("t4", start + 3, 20);
        bus.IF_Addr = 32'h0000_5010; if_left = 1; bus.IF_Req = 1'b1;
        push_burst(REQ_IF, 32'h0000_5010);
        push_burst(REQ_DF, 32'h0000_3008);
        drain("t4", 120);
        check("t4_if_completions", 32'(comp_if), 32'd1);
        check("t4_df_completions", 32'(comp_df), 32'd2);

        // Reset in the middle of a DF burst, then a clean IF fill
        do_reset();
        bus.DF_Addr = 32'h0000_2048; df_left = 1; bus.DF_Req = 1'b1;
        push_burst(REQ_DF, 32'h0000_2048);
        start = beats_seen;
        wait_beats("t5", start + 4, 20);
        Rst = 1'b1; bus.DF_Req = 1'b0; df_left = 0;
        sbq.delete();
        done_pending = 1'b0;
        tick();
        check("t5_mem_req", 32'(bus.Mem_Req), 32'd0);
        check("t5_busy", 32'(Busy), 32'd0);
        tick();
        Rst = 1'b0;
        tick();
        bus.IF_Addr = 32'h0000_0104; if_left = 1; bus.IF_Req = 1'b1;
        push_burst(REQ_IF, 32'h0000_0104);
        drain("t5", 40);
        check("t5_df_completions", 32'(comp_df), 32'd0);
        check("t5_if_completions", 32'(comp_if), 32'd1);

        // IF_Req dropped after two beats: burst still finishes
        do_reset();
        bus.IF_Addr = 32'h0000_0A38; if_left = 0; bus.IF_Req = 1'b1;
        push_burst(REQ_IF, 32'h0000_0A38);
        start = beats_seen;
        wait_beats("t6", start + 2, 20);
        bus.IF_Req = 1'b0;
        drain("t6", 40);
        check("t6_if_completions", 32'(comp_if), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
